// File: rtl/stream_checker.sv
// Self-checking sink for one arf output port: drives req, accepts words on ack,
// and compares each one against the affine producer model scale*x + offset.
module stream_checker #(
    parameter int data_width     = 32,
    parameter int consumer_id    = 0,
    parameter int scale          = 3,
    parameter int offset         = 2,
    parameter int initial_value  = 0,
    parameter int step           = 1,
    parameter int max_data_size  = 5000,
    parameter int timeout_cycles = 1000,
    parameter int stall_period   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req,
    input  logic                  ack,
    input  logic [data_width-1:0] din,
    output logic [31:0]           count,
    output logic [15:0]           err_count,
    output logic [31:0]           first_err_idx,
    output logic [data_width-1:0] first_err_data,
    output logic                  done,
    output logic                  timeout,
    output logic                  overrun
);

    localparam logic [data_width-1:0] SCALE_W = data_width'(scale);
    localparam logic [data_width-1:0] OFFS_W  = data_width'(offset);
    localparam logic [data_width-1:0] INIT_W  = data_width'(initial_value);
    localparam logic [data_width-1:0] STEP_W  = data_width'(step);
    localparam logic [data_width-1:0] EXP0    = SCALE_W * INIT_W + OFFS_W;
    localparam logic [data_width-1:0] EXP_INC = SCALE_W * STEP_W;

    localparam logic [31:0] MAX_W      = 32'(max_data_size);
    localparam logic [31:0] STALL_LAST = (stall_period > 0) ? 32'(stall_period - 1) : 32'd0;
    localparam logic [31:0] TMO_LAST   = (timeout_cycles > 0) ? 32'(timeout_cycles - 1) : 32'd0;

    typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;

    state_t                state;
    state_t                state_next;
    logic [data_width-1:0] expected;
    logic [31:0]           idle_cnt;
    logic [31:0]           stall_cnt;
    logic                  stall_hit;
    logic                  last_word;
    logic                  idle_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign stall_hit = (stall_period > 0) && (stall_cnt == STALL_LAST);
    assign last_word = (count + 32'd1) == MAX_W;
    assign idle_hit  = (timeout_cycles > 0) && (idle_cnt == TMO_LAST);

    // An accepted ack always beats the idle threshold in the same cycle.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        case (state)
            IDLE: state_next = (max_data_size == 0) ? DONE : RUN;
            RUN: begin
                req = !stall_hit;
                if (ack) begin
                    if (last_word) state_next = DONE;
                end else if (idle_hit) begin
                    state_next = TMO;
                end
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            expected       <= EXP0;
            idle_cnt       <= '0;
            stall_cnt      <= '0;
        end else begin
            state   <= state_next;
            done    <= (state_next == DONE);
            timeout <= (state_next == TMO);
            case (state)
                RUN: begin
                    stall_cnt <= stall_hit ? 32'd0 : stall_cnt + 32'd1;
                    if (ack) begin
                        count    <= count + 32'd1;
                        expected <= expected + EXP_INC;
                        idle_cnt <= '0;
                        $write("c_%0d, %0d\n", consumer_id, din);
                        if (din != expected) begin
                            err_count <= sat_inc(err_count);
                            if (err_count == 16'd0) begin
                                first_err_idx  <= count;
                                first_err_data <= din;
                            end
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                DONE: if (ack) overrun <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: an ideal arf upstream model feeds two instances
// (plain and stalling); a scoreboard checks every accepted word.
module tb_stream_checker;

    logic        clk = 1'b0;
    logic        rst_s    [2];
    logic        req_s    [2];
    logic        ack_s    [2];
    logic [31:0] din_s    [2];
    logic [31:0] cnt_s    [2];
    logic [15:0] err_s    [2];
    logic [31:0] fidx_s   [2];
    logic [31:0] fdata_s  [2];
    logic        done_s   [2];
    logic        tmo_s    [2];
    logic        ovr_s    [2];

    always #5 clk = ~clk;

    stream_checker #(.max_data_size(4), .timeout_cycles(10), .stall_period(0), .consumer_id(0)) u_plain (
        .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .ack(ack_s[0]), .din(din_s[0]),
        .count(cnt_s[0]), .err_count(err_s[0]), .first_err_idx(fidx_s[0]),
        .first_err_data(fdata_s[0]), .done(done_s[0]), .timeout(tmo_s[0]), .overrun(ovr_s[0]));

    stream_checker #(.max_data_size(8), .timeout_cycles(10), .stall_period(4), .consumer_id(1)) u_stall (
        .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .ack(ack_s[1]), .din(din_s[1]),
        .count(cnt_s[1]), .err_count(err_s[1]), .first_err_idx(fidx_s[1]),
        .first_err_data(fdata_s[1]), .done(done_s[1]), .timeout(tmo_s[1]), .overrun(ovr_s[1]));

    typedef struct {int cnt; int err; bit dn;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int          n_total = 0;
    int          n_pass  = 0;
    bit          up_en [2];
    bit          inj   [2];
    int          limit [2];
    int          sent  [2];
    int          err_m [2];
    int          maxw  [2];
    logic [31:0] corr  [2];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Ideal upstream: ack one cycle after every cycle in which req was seen high.
    initial begin
        bit          r [2];
        logic [31:0] m;
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i < 2; i++) begin
            ack_s[i] = 1'b0;
            din_s[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) r[i] = req_s[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (inj[i]) begin
                    ack_s[i] = 1'b1;
                    din_s[i] = 32'hDEAD_BEEF;
                    inj[i]   = 1'b0;
                end else if (up_en[i] && r[i] && sent[i] < limit[i]) begin
                    m = 32'(3 * sent[i] + 2);
                    d = m + (corr[i][sent[i]] ? 32'd1 : 32'd0);
                    if (d != m) err_m[i]++;
                    ack_s[i] = 1'b1;
                    din_s[i] = d;
                    sent[i]++;
                    e.cnt = sent[i];
                    e.err = err_m[i];
                    e.dn  = (sent[i] == maxw[i]);
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end else begin
                    ack_s[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: every time a count advances, pop the matching expectation.
    initial begin
        int   prev [2];
        exp_t e;
        bit   got;
        prev[0] = 0;
        prev[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (int'(cnt_s[i]) != prev[i]) begin
                    prev[i] = int'(cnt_s[i]);
                    if (prev[i] != 0) begin
                        got = 1'b0;
                        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                        if (!got) check("sb_unexpected_word", prev[i], -1);
                        else begin
                            check("sb_count", cnt_s[i], e.cnt);
                            check("sb_err_count", err_s[i], e.err);
                            check("sb_done", done_s[i], e.dn);
                            if (e.dn) check("sb_req_after_done", req_s[i], 0);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cnt(input int i, input int n, input int budget, input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (int'(cnt_s[i]) != n && k < budget);
        check(name, cnt_s[i], n);
    endtask

    task automatic clear_model(input int i, input int lim, input logic [31:0] c);
        sent[i]  = 0;
        err_m[i] = 0;
        limit[i] = lim;
        corr[i]  = c;
        if (i == 0) q0.delete();
        else        q1.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, cnt_s[0], 0);
        check({tag, "_err"}, err_s[0], 0);
        check({tag, "_fidx"}, fidx_s[0], 0);
        check({tag, "_fdata"}, fdata_s[0], 0);
        check({tag, "_done"}, done_s[0], 0);
        check({tag, "_timeout"}, tmo_s[0], 0);
        check({tag, "_overrun"}, ovr_s[0], 0);
        check({tag, "_req"}, req_s[0], 0);
    endtask

    task automatic restart_a(input int lim, input logic [31:0] c);
        @(posedge clk);
        #2;
        up_en[0] = 1'b0;
        rst_s[0] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        clear_model(0, lim, c);
        rst_s[0] = 1'b0;
        up_en[0] = 1'b1;
    endtask

    initial begin
        bit pat [8];
        pat = '{1, 1, 1, 0, 1, 1, 1, 0};
        maxw[0] = 4;
        maxw[1] = 8;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1;
            up_en[i] = 1'b0;
            inj[i]   = 1'b0;
            clear_model(i, 0, '0);
        end
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        check("reset_stall_req", req_s[1], 0);

        // Clean run on both instances; the stalling one also gets its req pattern checked.
        clear_model(0, 4, '0);
        clear_model(1, 8, '0);
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        up_en[0] = 1'b1;
        up_en[1] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("stall_req_%0d", k), req_s[1], pat[k]);
        end
        wait_cnt(0, 4, 50, "clean_count");
        check("clean_err", err_s[0], 0);
        check("clean_done", done_s[0], 1);
        check("clean_req", req_s[0], 0);
        wait_cnt(1, 8, 50, "stall_count");
        check("stall_err", err_s[1], 0);
        check("stall_done", done_s[1], 1);

        // Extra ack after done.
        check("pre_overrun", ovr_s[0], 0);
        inj[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("overrun_flag", ovr_s[0], 1);
        check("overrun_count", cnt_s[0], 4);
        check("overrun_err", err_s[0], 0);

        // Corrupt the 3rd and 4th words.
        restart_a(4, 32'b1100);
        wait_cnt(0, 4, 50, "corrupt_count");
        check("corrupt_err", err_s[0], 2);
        check("corrupt_fidx", fidx_s[0], 2);
        check("corrupt_fdata", fdata_s[0], 9);
        check("corrupt_done", done_s[0], 1);

        // Upstream stops after two words.
        restart_a(2, '0);
        wait_cnt(0, 2, 50, "tmo_count_reached");
        repeat (9) @(negedge clk);
        check("tmo_not_yet", tmo_s[0], 0);
        @(negedge clk);
        check("tmo_flag", tmo_s[0], 1);
        check("tmo_req", req_s[0], 0);
        check("tmo_count", cnt_s[0], 2);
        check("tmo_done", done_s[0], 0);

        // One-cycle reset in the middle of a run, then a fresh run.
        restart_a(4, '0);
        wait_cnt(0, 3, 50, "mid_count3");
        rst_s[0] = 1'b1;
        up_en[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_s[0] = 1'b0;
        clear_model(0, 4, '0);
        check_reset_vals("midrst");
        up_en[0] = 1'b1;
        wait_cnt(0, 4, 50, "rerun_count");
        check("rerun_err", err_s[0], 0);
        check("rerun_done", done_s[0], 1);

        repeat (3) @(negedge clk);
        check("sb_drain_plain", q0.size(), 0);
        check("sb_drain_stall", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stream_checker.md
Name: stream_checker

Overview:
- Self-checking sink for one arf output port, replacing the plain consumer in generated benches.
- Drives the consumer side of the req/ack handshake and counts accepted words.
- Compares each accepted word against an affine reference model, dout = scale*x + offset, where x is the producer sequence initial_value + step*n.
- Flags data mismatches, stalls (timeout) and overruns; raises done after max_data_size words.

Parameters:
- data_width, 32: data bus width; all model arithmetic is modulo 2^data_width.
- consumer_id, 0: index printed in $write trace lines.
- scale, 3: model multiplier. Default matches the arf chain in0 -> addi2 -> add -> add, i.e. 3x+2.
- offset, 2: model additive constant.
- initial_value, 0: first producer value x0.
- step, 1: producer increment per word.
- max_data_size, 5000: words to accept before done.
- timeout_cycles, 1000: cycles without ack in RUN before timeout; 0 disables the timeout.
- stall_period, 0: if >0, req is dropped for 1 cycle every stall_period cycles of RUN; 0 means req is held high.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  out  1  request to upstream out_* operator
- ack  in  1  upstream acknowledge; din is valid in every cycle ack=1
- din  in  data_width  data from upstream
- count  out  32  words accepted
- err_count  out  16  mismatching words, saturating at 16'hFFFF
- first_err_idx  out  32  count value at the first mismatch
- first_err_data  out  data_width  din at the first mismatch
- done  out  1  count reached max_data_size (sticky)
- timeout  out  1  no ack for timeout_cycles (sticky)
- overrun  out  1  ack seen after done (sticky)

Behaviour:
- Reset, applied at any time including mid-run, sets:
  - req=0, count=0, err_count=0, first_err_idx=0, first_err_data=0, done=0, timeout=0, overrun=0.
  - expected=scale*initial_value+offset; idle counter=0; stall counter=0; state=IDLE.
- States: IDLE, RUN, DONE, TMO.
- IDLE: lasts one cycle after rst deasserts, then -> RUN. req goes to 1 in the first RUN cycle.
- RUN, req:
  - req=1 except when stall_period>0 and the stall counter equals stall_period-1; in that cycle req=0.
  - The stall counter wraps from stall_period-1 to 0.
- RUN, each cycle with ack=1:
  - count<=count+1.
  - expected<=expected+scale*step (wrap at 2^data_width).
  - idle counter<=0.
  - Print "c_<consumer_id>, <din>" via $write.
  - If din!=expected: err_count increments (saturating). If err_count==0 beforehand, capture first_err_idx<=count and first_err_data<=din.
- ack arriving in a cycle where req=0 (a response to an earlier req) is accepted and checked normally.
- RUN, ack=0: idle counter increments. If timeout_cycles>0 and the idle counter reaches timeout_cycles-1 -> TMO.
- RUN -> DONE when an accepted ack makes count equal max_data_size. Output changes take effect the next cycle, i.e. done and req=0 are registered with the final count.
- DONE: req=0; done=1 held. Any ack sets overrun=1 and does not change count or err_count.
- TMO: req=0, timeout=1, counters frozen. Only rst exits; DONE likewise.
- Simultaneous ack and timeout threshold in the same cycle: ack wins (idle counter clears, stay in RUN).
- max_data_size=0: enter DONE directly from IDLE, never asserting req.
- Scoring for the bench is unchanged: throughput is computed externally from count and cycles.

Test Plan:
- Reset, then drive an ideal arf model with x=0,1,2,... and ack one cycle after each req, max_data_size=4 -> din 2,5,8,11 accepted; count=4, err_count=0, done=1, req=0 from the cycle after the 4th ack.
- Same run, corrupt the 3rd word (8 -> 9) and the 4th word -> err_count=2, first_err_idx=2, first_err_data=9, done=1.
- Upstream stops acking after 2 words, timeout_cycles=10 -> timeout=1 exactly 10 cycles after the last ack, req=0, count=2, done=0.
- stall_period=4 with always-ready upstream -> req low in every 4th RUN cycle (pattern 1,1,1,0); all words are still checked correctly.
- After done, inject one extra ack -> overrun=1; count stays at max_data_size and err_count is unchanged.
- Assert rst for one cycle mid-run at count=3 -> all outputs return to reset values; the next run restarts with expected=2.
